// File: rtl/display_tx_arbiter.sv
// Display transmit arbiter: a CPU byte FIFO and an optional debug requester share one UART transmitter.
// Optional debug source enabled by defining DISPLAY_TX_DBG_EN; default build sends CPU bytes only.
module display_tx_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Ddr_Wr,
  input  logic [7:0]  i_Ddr_Data,
  output logic [15:0] o_Dsr,
  output logic        o_Ovf,
  input  logic        i_Dbg_Req,
  input  logic [7:0]  i_Dbg_Byte,
  output logic        o_Dbg_Ack,
  output logic        o_Tx_DV,
  output logic [7:0]  o_Tx_Byte,
  input  logic        i_Tx_Done,
  output logic        o_Busy,
  output logic [1:0]  o_Fsm_State
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_full, fifo_empty;
  logic          push, pop;
  logic          grant_cpu, grant_dbg, any_grant;
  logic [7:0]    grant_byte;

  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  // A write into a full FIFO is dropped even if a pop happens on the same edge.
  assign push       = i_Ddr_Wr && !fifo_full;
  assign pop        = grant_cpu;
  assign o_Dsr      = {~fifo_full, 15'b0};

  always_ff @(posedge i_Clock) begin
    if (push) mem[wr_ptr] <= i_Ddr_Data;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      o_Ovf  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (i_Ddr_Wr && fifo_full) o_Ovf <= 1'b1;
    end
  end

`ifdef DISPLAY_TX_DBG_EN
  // last_grant_dbg=1 means the debug port won most recently, so the CPU wins the next tie.
  logic last_grant_dbg;

  always_comb begin
    grant_cpu = 1'b0;
    grant_dbg = 1'b0;
    if (state == ST_IDLE) begin
      if (!fifo_empty && i_Dbg_Req) begin
        grant_cpu = last_grant_dbg;
        grant_dbg = !last_grant_dbg;
      end else begin
        grant_cpu = !fifo_empty;
        grant_dbg = i_Dbg_Req;
      end
    end
  end

  assign grant_byte = grant_cpu ? mem[rd_ptr] : i_Dbg_Byte;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      last_grant_dbg <= 1'b1;
      o_Dbg_Ack      <= 1'b0;
    end else begin
      if (grant_cpu)      last_grant_dbg <= 1'b0;
      else if (grant_dbg) last_grant_dbg <= 1'b1;
      o_Dbg_Ack <= grant_dbg;
    end
  end
`else
  logic dbg_unused;

  assign dbg_unused = ^{i_Dbg_Req, i_Dbg_Byte};
  assign grant_cpu  = (state == ST_IDLE) && !fifo_empty;
  assign grant_dbg  = 1'b0;
  assign grant_byte = mem[rd_ptr];
  assign o_Dbg_Ack  = 1'b0;
`endif

  assign any_grant = grant_cpu || grant_dbg;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (any_grant) state_nxt = ST_SEND;
      ST_SEND: state_nxt = ST_WAIT;
      ST_WAIT: if (i_Tx_Done) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_Tx_DV     = (state == ST_SEND);
    o_Busy      = (state != ST_IDLE);
    o_Fsm_State = state;
  end

  // The byte is captured at grant time and held until the next grant.
  always_ff @(posedge i_Clock) begin
    if (i_Reset)        o_Tx_Byte <= 8'h00;
    else if (any_grant) o_Tx_Byte <= grant_byte;
  end

endmodule

// File: tb/tb_display_tx_arbiter.sv
// Bench for display_tx_arbiter: cycle vector table plus hand sequences for the multi-cycle cases.
// Works with or without DISPLAY_TX_DBG_EN defined.
module tb_display_tx_arbiter;

  logic        i_Clock = 1'b0;
  logic        i_Reset = 1'b0;
  logic        i_Ddr_Wr = 1'b0;
  logic [7:0]  i_Ddr_Data = 8'h00;
  logic [15:0] o_Dsr;
  logic        o_Ovf;
  logic        i_Dbg_Req = 1'b0;
  logic [7:0]  i_Dbg_Byte = 8'h00;
  logic        o_Dbg_Ack;
  logic        o_Tx_DV;
  logic [7:0]  o_Tx_Byte;
  logic        i_Tx_Done = 1'b0;
  logic        o_Busy;
  logic [1:0]  o_Fsm_State;

  int          total = 0;
  int          bad = 0;
  logic        mon_en = 1'b0;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_b;

  display_tx_arbiter #(.FIFO_DEPTH(4)) dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Ddr_Wr(i_Ddr_Wr), .i_Ddr_Data(i_Ddr_Data),
    .o_Dsr(o_Dsr), .o_Ovf(o_Ovf), .i_Dbg_Req(i_Dbg_Req), .i_Dbg_Byte(i_Dbg_Byte),
    .o_Dbg_Ack(o_Dbg_Ack), .o_Tx_DV(o_Tx_DV), .o_Tx_Byte(o_Tx_Byte), .i_Tx_Done(i_Tx_Done),
    .o_Busy(o_Busy), .o_Fsm_State(o_Fsm_State)
  );

  // clock / watchdog
  always #5 i_Clock = ~i_Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_Clock);
    #1;
  endtask

  // scoreboard: every transmit start must match the head of exp_q
  always @(posedge i_Clock) begin
    #1;
    if (mon_en && o_Tx_DV) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_dv: got byte %h want no start", o_Tx_Byte);
      end else begin
        exp_b = exp_q.pop_front();
        check("tx_order", {8'h00, o_Tx_Byte}, {8'h00, exp_b});
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    i_Reset = 1'b1;
    tick();
    i_Reset = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] d);
    i_Ddr_Wr = 1'b1;
    i_Ddr_Data = d;
    tick();
    i_Ddr_Wr = 1'b0;
  endtask

  task automatic step(inout int acks);
    tick();
    if (o_Dbg_Ack) begin
      acks++;
      i_Dbg_Req = 1'b0;
    end
  endtask

  // Transmitter model: answers each start with a done pulse two cycles later.
  task automatic drain(input int nbytes, inout int acks);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    while (got < nbytes && cyc < 100) begin
      step(acks);
      cyc++;
      if (o_Tx_DV) begin
        got++;
        step(acks);
        i_Tx_Done = 1'b1;
        step(acks);
        i_Tx_Done = 1'b0;
      end
    end
    check("drain_count", 16'(got), 16'(nbytes));
  endtask

  typedef struct {
    logic        rst;
    logic        wr;
    logic [7:0]  data;
    logic        done;
    logic [15:0] dsr;
    logic        busy;
    logic        dv;
    logic [7:0]  tx_byte;
    logic        ovf;
  } vec_t;

  function automatic vec_t v(input logic rst, input logic wr, input logic [7:0] data,
                             input logic done, input logic [15:0] dsr, input logic busy,
                             input logic dv, input logic [7:0] tx_byte, input logic ovf);
    vec_t r;
    r.rst = rst; r.wr = wr; r.data = data; r.done = done;
    r.dsr = dsr; r.busy = busy; r.dv = dv; r.tx_byte = tx_byte; r.ovf = ovf;
    return r;
  endfunction

  vec_t vecs[$];

  initial begin
    int acks;
    // reset, one byte with two-edge latency, then fill to full while held in WAIT
    //                rst wr data   done dsr       busy dv byte   ovf
    vecs.push_back(v(1, 0, 8'h00, 0, 16'h8000, 0, 0, 8'h00, 0));
    vecs.push_back(v(0, 1, 8'h41, 0, 16'h8000, 0, 0, 8'h00, 0));
    vecs.push_back(v(0, 0, 8'h00, 0, 16'h8000, 1, 1, 8'h41, 0));
    vecs.push_back(v(0, 0, 8'h00, 0, 16'h8000, 1, 0, 8'h41, 0));
    vecs.push_back(v(0, 1, 8'h01, 0, 16'h8000, 1, 0, 8'h41, 0));
    vecs.push_back(v(0, 1, 8'h02, 0, 16'h8000, 1, 0, 8'h41, 0));
    vecs.push_back(v(0, 1, 8'h03, 0, 16'h8000, 1, 0, 8'h41, 0));
    vecs.push_back(v(0, 1, 8'h04, 0, 16'h0000, 1, 0, 8'h41, 0));
    vecs.push_back(v(0, 1, 8'h05, 0, 16'h0000, 1, 0, 8'h41, 1));
    vecs.push_back(v(0, 0, 8'h00, 1, 16'h0000, 0, 0, 8'h41, 1));
    vecs.push_back(v(0, 0, 8'h00, 0, 16'h8000, 1, 1, 8'h01, 1));
    vecs.push_back(v(0, 0, 8'h00, 1, 16'h8000, 1, 0, 8'h01, 1));
    vecs.push_back(v(0, 0, 8'h00, 1, 16'h8000, 0, 0, 8'h01, 1));
    vecs.push_back(v(0, 0, 8'h00, 0, 16'h8000, 1, 1, 8'h02, 1));
    vecs.push_back(v(0, 0, 8'h00, 0, 16'h8000, 1, 0, 8'h02, 1));
    vecs.push_back(v(0, 0, 8'h00, 1, 16'h8000, 0, 0, 8'h02, 1));
    vecs.push_back(v(0, 0, 8'h00, 0, 16'h8000, 1, 1, 8'h03, 1));
    vecs.push_back(v(0, 0, 8'h00, 0, 16'h8000, 1, 0, 8'h03, 1));
    vecs.push_back(v(0, 0, 8'h00, 1, 16'h8000, 0, 0, 8'h03, 1));
    vecs.push_back(v(0, 0, 8'h00, 0, 16'h8000, 1, 1, 8'h04, 1));
    vecs.push_back(v(0, 0, 8'h00, 0, 16'h8000, 1, 0, 8'h04, 1));
    vecs.push_back(v(0, 0, 8'h00, 1, 16'h8000, 0, 0, 8'h04, 1));
    vecs.push_back(v(0, 0, 8'h00, 0, 16'h8000, 0, 0, 8'h04, 1));
    vecs.push_back(v(1, 0, 8'h00, 0, 16'h8000, 0, 0, 8'h00, 0));

    acks = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      i_Reset = vecs[i].rst;
      i_Ddr_Wr = vecs[i].wr;
      i_Ddr_Data = vecs[i].data;
      i_Tx_Done = vecs[i].done;
      tick();
      check($sformatf("vec%0d_dsr", i), o_Dsr, vecs[i].dsr);
      check($sformatf("vec%0d_busy", i), {15'b0, o_Busy}, {15'b0, vecs[i].busy});
      check($sformatf("vec%0d_dv", i), {15'b0, o_Tx_DV}, {15'b0, vecs[i].dv});
      check($sformatf("vec%0d_byte", i), {8'h00, o_Tx_Byte}, {8'h00, vecs[i].tx_byte});
      check($sformatf("vec%0d_ovf", i), {15'b0, o_Ovf}, {15'b0, vecs[i].ovf});
    end
    i_Reset = 1'b0;
    i_Ddr_Wr = 1'b0;
    i_Tx_Done = 1'b0;
    check("reset_state", {14'b0, o_Fsm_State}, 16'h0000);

    // write on the same edge as a pop at count=2: count must stay 2
    mon_en = 1'b1;
    do_reset();
    exp_q.push_back(8'hA0);
    wr_byte(8'hA0);
    tick();
    tick();
    wr_byte(8'hA1);
    wr_byte(8'hA2);
    i_Tx_Done = 1'b1;
    tick();
    i_Tx_Done = 1'b0;
    exp_q.push_back(8'hA1);
    wr_byte(8'hA3);
    check("pp_dsr_after_pop_push", o_Dsr, 16'h8000);
    wr_byte(8'hB0);
    check("pp_dsr_count3", o_Dsr, 16'h8000);
    wr_byte(8'hB1);
    check("pp_dsr_count4_full", o_Dsr, 16'h0000);
    i_Tx_Done = 1'b1;
    tick();
    i_Tx_Done = 1'b0;
    exp_q.push_back(8'hA2);
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'hB0);
    exp_q.push_back(8'hB1);
    drain(4, acks);
    check("pp_no_ovf", {15'b0, o_Ovf}, 16'h0000);
    check("pp_queue_empty", 16'(exp_q.size()), 16'h0000);

    // reset in WAIT with three bytes queued, colliding with a write and a done
    do_reset();
    exp_q.push_back(8'hC0);
    wr_byte(8'hC0);
    wr_byte(8'hC1);
    wr_byte(8'hC2);
    wr_byte(8'hC3);
    check("rst_busy_before", {15'b0, o_Busy}, 16'h0001);
    i_Reset = 1'b1;
    i_Ddr_Wr = 1'b1;
    i_Ddr_Data = 8'hFF;
    i_Tx_Done = 1'b1;
    tick();
    i_Reset = 1'b0;
    i_Ddr_Wr = 1'b0;
    i_Tx_Done = 1'b0;
    check("rst_busy", {15'b0, o_Busy}, 16'h0000);
    check("rst_dsr", o_Dsr, 16'h8000);
    check("rst_byte", {8'h00, o_Tx_Byte}, 16'h0000);
    check("rst_dbg_ack", {15'b0, o_Dbg_Ack}, 16'h0000);
    for (int i = 0; i < 10; i++) tick();
    check("rst_idle_after", {15'b0, o_Busy}, 16'h0000);
    check("rst_queue_empty", 16'(exp_q.size()), 16'h0000);

    // debug requester against two queued CPU bytes
    do_reset();
    acks = 0;
    i_Dbg_Byte = 8'hAA;
    exp_q.push_back(8'h10);
    wr_byte(8'h10);
    i_Dbg_Req = 1'b1;
    wr_byte(8'h11);
    step(acks);
    i_Tx_Done = 1'b1;
    step(acks);
    i_Tx_Done = 1'b0;
`ifdef DISPLAY_TX_DBG_EN
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h11);
    drain(2, acks);
    check("dbg_ack_count", 16'(acks), 16'h0001);
`else
    exp_q.push_back(8'h11);
    drain(1, acks);
    for (int i = 0; i < 6; i++) step(acks);
    check("dbg_ack_never", 16'(acks), 16'h0000);
    check("dbg_req_ignored_idle", {15'b0, o_Busy}, 16'h0000);
`endif
    i_Dbg_Req = 1'b0;
    check("dbg_queue_empty", 16'(exp_q.size()), 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
